instr_assembler: RTL

Encode-side counterpart of the instruction decoder. It accepts structured instruction requests (format, register indices, funct fields, immediate) over a valid/ready handshake and encodes each one into a 32-bit RV32I word. The word is byteswapped into the same memory byte order the decoder consumes. Each result is tagged with a sequential instruction address and buffered in a small FIFO. The block sits between the test/boot program generator and instruction memory.

---
 rtl/instr_assembler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/instr_assembler.sv
// RV32I instruction assembler: encodes structured requests into byteswapped
// 32-bit words, tags each with a sequential address and buffers it in a FIFO.
module instr_assembler #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_format,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    FMT_OP     = 3'd0,
    FMT_OP_IMM = 3'd1,
    FMT_LOAD   = 3'd2,
    FMT_STORE  = 3'd3,
    FMT_BRANCH = 3'd4,
    FMT_JAL    = 3'd5,
    FMT_EBREAK = 3'd6,
    FMT_RSVD   = 3'd7
  } fmt_e;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] EBREAK_W   = 32'h0010_0073;

  // True when v is representable as a bits-wide two's-complement value,
  // i.e. everything from bit (bits-1) upward is a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (bits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

  // ---------------------------------------------------------------------------
  // Encoder
  // ---------------------------------------------------------------------------
  fmt_e        fmt;
  logic        is_shift;
  logic [31:0] enc_word;
  logic        enc_ok;
  logic [31:0] enc_swapped;

  assign fmt      = fmt_e'(req_format);
  assign is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    unique case (fmt)
      FMT_OP: begin
        enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OPC_OP};
        enc_ok   = 1'b1;
      end
      FMT_OP_IMM: begin
        if (is_shift) begin
          enc_word = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, OPC_OP_IMM};
          enc_ok   = (req_imm[31:5] == '0);
        end else begin
          enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OP_IMM};
          enc_ok   = fits_signed(req_imm, 12);
        end
      end
      FMT_LOAD: begin
        enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
        enc_ok   = fits_signed(req_imm, 12);
      end
      FMT_STORE: begin
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
        enc_ok   = fits_signed(req_imm, 12);
      end
      FMT_BRANCH: begin
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], OPC_BRANCH};
        enc_ok   = fits_signed(req_imm, 13) && !req_imm[0];
      end
      FMT_JAL: begin
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
        enc_ok   = fits_signed(req_imm, 21) && !req_imm[0];
      end
      FMT_EBREAK: begin
        enc_word = EBREAK_W;
        enc_ok   = 1'b1;
      end
      FMT_RSVD: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // Instruction memory consumes the word least-significant byte first.
  assign enc_swapped = {enc_word[7:0], enc_word[15:8], enc_word[23:16], enc_word[31:24]};

  // ---------------------------------------------------------------------------
  // Handshake and FIFO control
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [31:0]      addr_cnt_q, addr_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;

  logic accept, push, pop, reject;

  assign req_ready = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // A request is consumed whenever it handshakes; flush discards it silently.
  assign accept = req_valid && req_ready;
  assign push   = accept && enc_ok && !flush;
  assign reject = accept && !enc_ok && !flush;
  assign pop    = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    addr_cnt_d  = addr_cnt_q;
    err_pulse_d = reject;
    err_count_d = err_count_q;

    if (reject && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      addr_cnt_d = BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        addr_cnt_d = addr_cnt_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      addr_cnt_q  <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      addr_cnt_q  <= addr_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] data_mem_q [DEPTH];
  logic [31:0] addr_mem_q [DEPTH];

  // NOTE: the storage array has no reset; validity lives entirely in count_q,
  // and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= enc_swapped;
      addr_mem_q[wr_ptr_q] <= addr_cnt_q;
    end
  end

  // With nothing buffered the address port shows where the next word will land.
  assign out_data  = out_valid ? data_mem_q[rd_ptr_q] : 32'h0;
  assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q] : addr_cnt_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
